pulp_clock_toggle_gen: RTL and testbench
========================================

// Module: pulp_clock_toggle_gen
// PURPOSE
//  Generates the two toggle-encoded clock-phase signals consumed by a downstream clock XOR2 cell.
//  clk0_o toggles to start each high phase; clk1_o toggles to start each low phase.
//  Their XOR is therefore a divided clock with programmable high/low length.
//  The XOR output is glitch-free: it never changes more than once per clk_i cycle.
//  Sits in the clock-generation path, in front of the XOR2 cell.
//  Configured through a valid/ready port from the SoC control logic.
// PARAMETERS
//  CNT_WIDTH  8  width of the high/low phase length fields and the internal down-counter
// PORTS
//  clk_i          in   1          reference clock; all logic on its rising edge
//  rst_i          in   1          synchronous, active-high reset
//  en_i           in   1          run request for the divided clock
//  cfg_valid_i    in   1          new phase configuration offered
//  cfg_ready_o    out  1          configuration can be accepted
//  cfg_high_i     in   CNT_WIDTH  high-phase length in clk_i cycles (0 treated as 1)
//  cfg_low_i      in   CNT_WIDTH  low-phase length in clk_i cycles (0 treated as 1)
//  clk0_o         out  1          rising-phase toggle signal, registered
//  clk1_o         out  1          falling-phase toggle signal, registered
//  period_start_o out  1          one-cycle pulse in the first HIGH cycle of each period
//  busy_o         out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, except cfg_ready_o = 1.
//   - Active high/low lengths = 1/1; pending slot empty; FSM = IDLE.
//   - Reset mid-period forces clk0_o = clk1_o = 0 on the next edge; the partial period is dropped.
//  Config handshake:
//   - Transfer happens when cfg_valid_i && cfg_ready_o.
//   - Zero lengths are clamped to 1 at capture.
//   - The captured value goes to a one-entry pending slot; cfg_ready_o = 0 while the slot is full.
//   - The pending slot is copied to the active config only on entry to HIGH, at a period boundary.
//   - If in IDLE with the pending slot full, the config is copied the next cycle.
//   - A transfer in the same cycle as entry to HIGH is not applied to that period; it waits for the next boundary.
//  FSM (IDLE, HIGH, LOW); cnt is the down-counter:
//   - IDLE: if en_i, flip clk0_o and go to HIGH with cnt = act_high-1 (using the pending config if present).
//   - HIGH: if cnt == 0, flip clk1_o and go to LOW with cnt = act_low-1; otherwise cnt--.
//   - LOW, cnt != 0: cnt--.
//   - LOW, cnt == 0, en_i = 1: flip clk0_o, apply pending config, go to HIGH with cnt = act_high-1.
//   - LOW, cnt == 0, en_i = 0: go to IDLE; no toggle.
//  Invariants:
//   - (clk0_o ^ clk1_o) == 1 exactly while the FSM is in HIGH.
//   - At most one of clk0_o/clk1_o changes per cycle.
//  Latency:
//   - First high phase is visible 1 cycle after en_i is sampled high in IDLE.
//   - Period = high + low clk_i cycles.
//  en_i deasserted mid-period:
//   - The current period completes in full; no truncated high or low phase.
//   - en_i is sampled only in IDLE and at the LOW/cnt==0 decision.
//  period_start_o = 1 in the cycle the FSM is first in HIGH for a period.
//  busy_o = (state != IDLE).
// TESTING
//  1. Reset, hold en_i = 1, default config -> XOR = 0,1,0,1...; period_start_o every 2nd cycle;
//     clk0_o/clk1_o each toggle every 2 cycles.
//  2. cfg high = 3, low = 2 in IDLE, then en_i = 1 -> XOR = 1,1,1,0,0 repeating; period = 5.
//  3. Running 3/2; cfg 1/4 sent mid-HIGH -> cfg_ready_o = 0 until the next period start;
//     current period stays 3/2, the next is 1/4; a second cfg_valid_i is stalled meanwhile.
//  4. en_i drops in cycle 1 of HIGH (config 3/2) -> full 3 high + 2 low complete, then IDLE;
//     busy_o = 0; outputs held.
//  5. cfg 0/0 -> behaves as 1/1.
//     cfg 255/255 at CNT_WIDTH = 8 -> period 510, no counter wrap.
//  6. rst_i asserted in HIGH -> next edge: clk0_o = clk1_o = 0, IDLE, active config 1/1, cfg_ready_o = 1.
//  Every test checks each cycle: XOR == (state == HIGH), and never both outputs toggle in one cycle (except reset).

Source files
------------

// File: rtl/pulp_clock_toggle_gen.sv
// Toggle-encoded clock-phase generator: clk0_o flips to open each high phase,
// clk1_o flips to open each low phase, so their XOR is a programmable divided clock.
module pulp_clock_toggle_gen #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CNT_WIDTH-1:0] cfg_high_i,
  input  logic [CNT_WIDTH-1:0] cfg_low_i,
  output logic                 clk0_o,
  output logic                 clk1_o,
  output logic                 period_start_o,
  output logic                 busy_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] act_high_reg;
  logic [CNT_WIDTH-1:0] act_low_reg;
  logic [CNT_WIDTH-1:0] pend_high_reg;
  logic [CNT_WIDTH-1:0] pend_low_reg;
  logic                 pend_full_reg;
  logic                 clk0_reg;
  logic                 clk1_reg;
  logic                 period_start_reg;
  logic                 busy_reg;

  logic                 cfg_fire;
  logic                 start_period;
  logic                 take_pend;
  logic [CNT_WIDTH-1:0] cfg_high_clamped;
  logic [CNT_WIDTH-1:0] cfg_low_clamped;
  logic [CNT_WIDTH-1:0] start_high;

  assign cfg_fire         = cfg_valid_i && !pend_full_reg;
  assign cfg_high_clamped = (cfg_high_i == '0) ? ONE : cfg_high_i;
  assign cfg_low_clamped  = (cfg_low_i  == '0) ? ONE : cfg_low_i;

  // A new period opens from IDLE or at the last LOW cycle; en_i is only looked at there.
  assign start_period = en_i && ((state_reg == IDLE) ||
                                 ((state_reg == LOW) && (cnt_reg == '0)));

  // Pending config lands at a period boundary, or as soon as possible while idle.
  assign take_pend  = pend_full_reg && (start_period || (state_reg == IDLE));
  assign start_high = pend_full_reg ? pend_high_reg : act_high_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      act_high_reg     <= ONE;
      act_low_reg      <= ONE;
      pend_high_reg    <= ONE;
      pend_low_reg     <= ONE;
      pend_full_reg    <= 1'b0;
      clk0_reg         <= 1'b0;
      clk1_reg         <= 1'b0;
      period_start_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      period_start_reg <= 1'b0;

      if (take_pend) begin
        act_high_reg <= pend_high_reg;
        act_low_reg  <= pend_low_reg;
      end

      // cfg_fire needs an empty slot and take_pend a full one, so they never collide.
      if (cfg_fire) begin
        pend_full_reg <= 1'b1;
        pend_high_reg <= cfg_high_clamped;
        pend_low_reg  <= cfg_low_clamped;
      end else if (take_pend) begin
        pend_full_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start_period) begin
            clk0_reg         <= ~clk0_reg;
            cnt_reg          <= start_high - ONE;
            state_reg        <= HIGH;
            period_start_reg <= 1'b1;
            busy_reg         <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_reg == '0) begin
            clk1_reg  <= ~clk1_reg;
            cnt_reg   <= act_low_reg - ONE;
            state_reg <= LOW;
          end else begin
            cnt_reg <= cnt_reg - ONE;
          end
        end
        LOW: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - ONE;
          end else if (start_period) begin
            clk0_reg         <= ~clk0_reg;
            cnt_reg          <= start_high - ONE;
            state_reg        <= HIGH;
            period_start_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o    = !pend_full_reg;
  assign clk0_o         = clk0_reg;
  assign clk1_o         = clk1_reg;
  assign period_start_o = period_start_reg;
  assign busy_o         = busy_reg;

endmodule

// File: tb/tb_pulp_clock_toggle_gen.sv
// Bench for pulp_clock_toggle_gen: a queue of expected per-cycle phase values is
// rebuilt at every period start and compared against the DUT on every cycle.
module tb_pulp_clock_toggle_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [7:0] cfg_high_i;
  logic [7:0] cfg_low_i;
  logic       clk0_o;
  logic       clk1_o;
  logic       period_start_o;
  logic       busy_o;

  pulp_clock_toggle_gen #(.CNT_WIDTH(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_high_i     (cfg_high_i),
    .cfg_low_i      (cfg_low_i),
    .clk0_o         (clk0_o),
    .clk1_o         (clk1_o),
    .period_start_o (period_start_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model: each queue entry is one future clk_i cycle, {period_start, xor}.
  bit [1:0] q[$];
  int  act_h = 1, act_l = 1, pend_h = 1, pend_l = 1;
  bit  pend = 1'b0;
  bit  m_clk0 = 1'b0;
  bit  model_started = 1'b0;
  bit  rst_at_edge = 1'b1;

  always @(posedge clk_i) begin
    bit was_busy;
    bit rdy;
    model_started = 1'b1;
    rst_at_edge   = rst_i;
    if (rst_i) begin
      q.delete();
      m_clk0 = 1'b0;
      act_h = 1; act_l = 1;
      pend  = 1'b0;
    end else begin
      was_busy = (q.size() != 0);
      rdy      = !pend;
      if (was_busy) void'(q.pop_front());
      if (q.size() == 0) begin
        if (en_i) begin
          if (pend) begin act_h = pend_h; act_l = pend_l; pend = 1'b0; end
          for (int i = 0; i < act_h; i++) q.push_back((i == 0) ? 2'b11 : 2'b01);
          for (int i = 0; i < act_l; i++) q.push_back(2'b00);
          m_clk0 = ~m_clk0;
        end else if (!was_busy && pend) begin
          act_h = pend_h; act_l = pend_l; pend = 1'b0;
        end
      end
      if (cfg_valid_i && rdy) begin
        pend   = 1'b1;
        pend_h = (cfg_high_i == 0) ? 1 : int'(cfg_high_i);
        pend_l = (cfg_low_i  == 0) ? 1 : int'(cfg_low_i);
      end
    end
  end

  bit prev0, prev1, have_prev = 1'b0;

  always @(negedge clk_i) begin
    bit ex, eps;
    if (model_started) begin
      ex  = (q.size() != 0) ? q[0][0] : 1'b0;
      eps = (q.size() != 0) ? q[0][1] : 1'b0;
      check("m_clk0", clk0_o, m_clk0);
      check("m_clk1", clk1_o, m_clk0 ^ ex);
      check("m_period_start", period_start_o, eps);
      check("m_busy", busy_o, q.size() != 0);
      check("m_ready", cfg_ready_o, !pend);
      if (have_prev && !rst_at_edge)
        check("one_toggle", (clk0_o != prev0) && (clk1_o != prev1), 0);
      prev0 = clk0_o; prev1 = clk1_o; have_prev = 1'b1;
    end
  end

  task automatic send_cfg(input int h, input int l);
    int n = 0;
    cfg_valid_i = 1'b1;
    cfg_high_i  = 8'(h);
    cfg_low_i   = 8'(l);
    while (!cfg_ready_o && n < 1000) begin @(negedge clk_i); n++; end
    check("cfg_accept_timeout", cfg_ready_o, 1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_ps(input int bound);
    int n = 0;
    while (!period_start_o && n < bound) begin @(negedge clk_i); n++; end
    check("wait_ps_timeout", period_start_o, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy_o && n < bound) begin @(negedge clk_i); n++; end
    check("wait_idle_timeout", busy_o, 0);
  endtask

  logic [9:0] pat2 = 10'b0011100111;
  logic [7:0] pat3_x = 8'b00110000;
  logic [7:0] pat3_p = 8'b00010000;
  logic [7:0] pat4_x = 8'b00000111;
  logic [7:0] pat4_b = 8'b00011111;

  initial begin
    int n, hi, len;
    rst_i = 1'b1; en_i = 1'b0; cfg_valid_i = 1'b0; cfg_high_i = '0; cfg_low_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", cfg_ready_o, 1);
    check("rst_clk0", clk0_o, 0);
    check("rst_clk1", clk1_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ps", period_start_o, 0);
    rst_i = 1'b0;

    // Default 1/1 divided clock
    en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("t1_xor", clk0_o ^ clk1_o, (i % 2) == 0);
      check("t1_ps", period_start_o, (i % 2) == 0);
      check("t1_clk0", clk0_o, ((i / 2) % 2) == 0);
    end
    en_i = 1'b0;
    wait_idle(10);

    // 3/2 configured while idle
    send_cfg(3, 2);
    en_i = 1'b1;
    wait_ps(10);
    for (int i = 0; i < 10; i++) begin
      check("t2_xor", clk0_o ^ clk1_o, pat2[i]);
      @(negedge clk_i);
    end

    // Mid-HIGH reconfiguration to 1/4, with a second offer stalled behind it
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_high_i = 8'd1; cfg_low_i = 8'd4;
    @(negedge clk_i);
    cfg_high_i = 8'd2; cfg_low_i = 8'd2;
    check("t3_ready_low", cfg_ready_o, 0);
    check("t3_still_high", clk0_o ^ clk1_o, 1);
    n = 0;
    while (!cfg_ready_o && n < 20) begin @(negedge clk_i); n++; end
    check("t3_stall_cycles", n, 3);
    check("t3_ready_at_ps", period_start_o, 1);
    check("t3_new_high", clk0_o ^ clk1_o, 1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    check("t3_second_taken", cfg_ready_o, 0);
    for (int j = 0; j < 8; j++) begin
      check("t3_xor", clk0_o ^ clk1_o, pat3_x[j]);
      check("t3_ps", period_start_o, pat3_p[j]);
      @(negedge clk_i);
    end

    // en_i dropped in the first HIGH cycle of a 3/2 period
    send_cfg(3, 2);
    n = 0;
    while (!(period_start_o && cfg_ready_o) && n < 50) begin @(negedge clk_i); n++; end
    check("t4_sync_timeout", period_start_o && cfg_ready_o, 1);
    en_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t4_xor", clk0_o ^ clk1_o, pat4_x[k]);
      check("t4_busy", busy_o, pat4_b[k]);
      @(negedge clk_i);
    end

    // Zero lengths clamp to 1
    send_cfg(0, 0);
    en_i = 1'b1;
    wait_ps(10);
    for (int i = 0; i < 4; i++) begin
      check("t5_zero_xor", clk0_o ^ clk1_o, (i % 2) == 0);
      @(negedge clk_i);
    end
    en_i = 1'b0;
    wait_idle(10);

    // Maximum lengths
    send_cfg(255, 255);
    en_i = 1'b1;
    wait_ps(10);
    hi = 0; len = 0;
    do begin
      hi += int'(clk0_o ^ clk1_o);
      len++;
      @(negedge clk_i);
    end while (!period_start_o && len < 600);
    check("t5_max_period", len, 510);
    check("t5_max_high", hi, 255);
    en_i = 1'b0;
    wait_idle(600);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      rst_i       = ($urandom % 97) == 0;
      en_i        = ($urandom % 8) != 0;
      cfg_valid_i = ($urandom % 4) == 0;
      cfg_high_i  = 8'($urandom % 6);
      cfg_low_i   = 8'($urandom % 6);
    end

    // Reset during HIGH drops the period and restores 1/1
    @(negedge clk_i);
    rst_i = 1'b0; cfg_valid_i = 1'b0; en_i = 1'b1;
    n = 0;
    while (!(clk0_o ^ clk1_o) && n < 50) begin @(negedge clk_i); n++; end
    check("t6_find_high", clk0_o ^ clk1_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("t6_clk0", clk0_o, 0);
    check("t6_clk1", clk1_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_ready", cfg_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t6_xor", clk0_o ^ clk1_o, (i % 2) == 0);
    end
    en_i = 1'b0;
    repeat (5) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
